// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern engine: a prescaler paces blink, rotate, Johnson and ping-pong
// patterns, with run-time mode load and pause.
//
// state (mode_q) | meaning
// MODE_BLINK     | all LEDs toggle together each step
// MODE_ROTATE    | single hot bit circulates towards the MSB, wraps to bit0
// MODE_JOHNSON   | twisted-ring fill/empty, period 2*N_LED steps
// MODE_PINGPONG  | single hot bit bounces between bit0 and MSB, direction in dir_q
module led_pattern_gen #(
    parameter int N_LED       = 4,
    parameter int STEP_CYCLES = 25_000_000,
    parameter int CNT_W       = 25,
    parameter int RESET_MODE  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode_in,
    input  logic             mode_load,
    input  logic             pause,
    output logic [N_LED-1:0] led,
    output logic [1:0]       mode_cur,
    output logic             step
);

    typedef enum logic [1:0] {
        MODE_BLINK    = 2'd0,
        MODE_ROTATE   = 2'd1,
        MODE_JOHNSON  = 2'd2,
        MODE_PINGPONG = 2'd3
    } mode_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [N_LED-1:0] LED_BIT0  = N_LED'(1);
    localparam logic [1:0]       MODE_RST  = 2'(RESET_MODE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_t            mode_q, mode_d;
    dir_t             dir_q, dir_d;
    logic [N_LED-1:0] led_q, led_d;
    logic             step_q, step_d;
    logic             tick;

    function automatic logic [N_LED-1:0] init_led(input logic [1:0] m);
        if (m == MODE_ROTATE || m == MODE_PINGPONG)
            return LED_BIT0;
        return '0;
    endfunction

    function automatic logic is_onehot(input logic [N_LED-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    assign tick = !pause && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            mode_q <= mode_t'(MODE_RST);
            dir_q  <= DIR_LEFT;
            led_q  <= init_led(MODE_RST);
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
            dir_q  <= dir_d;
            led_q  <= led_d;
            step_q <= step_d;
        end
    end

    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_q;
        dir_d  = dir_q;
        led_d  = led_q;
        step_d = 1'b0;
        // A load restarts the pattern even when paused and swallows a coincident tick.
        if (mode_load) begin
            mode_d = mode_t'(mode_in);
            led_d  = init_led(mode_in);
            dir_d  = DIR_LEFT;
            cnt_d  = '0;
        end else if (!pause) begin
            if (tick) begin
                cnt_d  = '0;
                step_d = 1'b1;
                case (mode_q)
                    MODE_BLINK: begin
                        led_d = ~led_q;
                    end
                    MODE_ROTATE: begin
                        if (!is_onehot(led_q))
                            led_d = LED_BIT0;
                        else
                            led_d = {led_q[N_LED-2:0], led_q[N_LED-1]};
                    end
                    MODE_JOHNSON: begin
                        led_d = {led_q[N_LED-2:0], ~led_q[N_LED-1]};
                    end
                    MODE_PINGPONG: begin
                        // Corrupted vector recovers to bit0 heading left.
                        if (!is_onehot(led_q)) begin
                            led_d = LED_BIT0;
                            dir_d = DIR_LEFT;
                        end else if (dir_q == DIR_LEFT) begin
                            if (led_q[N_LED-1]) begin
                                led_d = led_q >> 1;
                                dir_d = DIR_RIGHT;
                            end else begin
                                led_d = led_q << 1;
                            end
                        end else begin
                            if (led_q[0]) begin
                                led_d = led_q << 1;
                                dir_d = DIR_LEFT;
                            end else begin
                                led_d = led_q >> 1;
                            end
                        end
                    end
                    default: begin
                        led_d = led_q;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign led      = led_q;
    assign mode_cur = mode_q;
    assign step     = step_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: a 4-LED instance for most modes and a
// 5-LED instance for the ping-pong bounce.
module tb_led_pattern_gen;

    logic       clk = 1'b0;
    logic       rst, mode_load, pause;
    logic [1:0] mode_in;
    logic [3:0] led;
    logic [1:0] mode_cur;
    logic       step;

    logic       b_rst, b_mode_load;
    logic [1:0] b_mode_in;
    logic [4:0] b_led;
    logic [1:0] b_mode_cur;
    logic       b_step;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    led_pattern_gen #(.N_LED(4), .STEP_CYCLES(4), .CNT_W(3), .RESET_MODE(1)) u_dut_a (
        .clk(clk), .rst(rst), .mode_in(mode_in), .mode_load(mode_load), .pause(pause),
        .led(led), .mode_cur(mode_cur), .step(step)
    );

    led_pattern_gen #(.N_LED(5), .STEP_CYCLES(4), .CNT_W(3), .RESET_MODE(1)) u_dut_b (
        .clk(clk), .rst(b_rst), .mode_in(b_mode_in), .mode_load(b_mode_load), .pause(1'b0),
        .led(b_led), .mode_cur(b_mode_cur), .step(b_step)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs 4 clocks per entry of exp_q; led must hold 'start' until the first
    // tick and then follow exp_q, with step high only on tick cycles.
    task automatic follow(input string tag, input logic [31:0] start, input bit use_b);
        int n;
        logic [31:0] e_led;
        n = exp_q.size() * 4;
        for (int k = 1; k <= n; k++) begin
            cyc();
            e_led = (k < 4) ? start : exp_q[k/4 - 1];
            if (use_b) begin
                check({tag, "_led"}, 32'(b_led), e_led);
                check({tag, "_step"}, 32'(b_step), 32'((k % 4) == 0));
            end else begin
                check({tag, "_led"}, 32'(led), e_led);
                check({tag, "_step"}, 32'(step), 32'((k % 4) == 0));
            end
        end
    endtask

    initial begin
        rst = 1'b1; mode_load = 1'b0; pause = 1'b0; mode_in = 2'd0;
        b_rst = 1'b1; b_mode_load = 1'b0; b_mode_in = 2'd0;
        cyc(); cyc();
        check("rst_led", 32'(led), 32'h1);
        check("rst_mode", 32'(mode_cur), 32'd1);
        check("rst_step", 32'(step), 32'd0);
        check("b_rst_led", 32'(b_led), 32'h01);

        // Rotate from reset: 0001 -> 0010 -> 0100 -> 1000 -> 0001 -> 0010
        rst = 1'b0;
        exp_q = {32'h2, 32'h4, 32'h8, 32'h1, 32'h2};
        follow("rot", 32'h1, 1'b0);

        // Johnson after load; counter was just wrapped, load also zeroes it
        mode_in = 2'd2; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        check("jn_load_led", 32'(led), 32'h0);
        check("jn_load_mode", 32'(mode_cur), 32'd2);
        check("jn_load_step", 32'(step), 32'd0);
        exp_q = {32'h1, 32'h3, 32'h7, 32'hf, 32'he, 32'hc, 32'h8, 32'h0};
        follow("jn", 32'h0, 1'b0);

        // Blink with pause held from cnt = 2
        mode_in = 2'd0; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        check("bl_load_mode", 32'(mode_cur), 32'd0);
        cyc(); cyc();
        pause = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("bl_pause_led", 32'(led), 32'h0);
            check("bl_pause_step", 32'(step), 32'd0);
        end
        pause = 1'b0;
        cyc();
        check("bl_rel1_led", 32'(led), 32'h0);
        cyc();
        check("bl_rel2_led", 32'(led), 32'hf);
        check("bl_rel2_step", 32'(step), 32'd1);

        // Load coinciding with a tick (cnt = 3): tick dropped, counter restarts
        cyc(); cyc();
        check("bl_hold_led", 32'(led), 32'hf);
        cyc();
        mode_in = 2'd1; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        check("lt_led", 32'(led), 32'h1);
        check("lt_step", 32'(step), 32'd0);
        check("lt_mode", 32'(mode_cur), 32'd1);
        exp_q = {32'h2};
        follow("lt", 32'h1, 1'b0);

        // Reset mid-Johnson at 0111; reset beats a simultaneous load
        mode_in = 2'd2; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        repeat (12) cyc();
        check("mr_pre_led", 32'(led), 32'h7);
        rst = 1'b1; mode_in = 2'd3; mode_load = 1'b1;
        cyc();
        rst = 1'b0; mode_load = 1'b0;
        check("mr_led", 32'(led), 32'h1);
        check("mr_mode", 32'(mode_cur), 32'd1);
        check("mr_step", 32'(step), 32'd0);

        // Ping-pong loaded while paused stays frozen at INIT until release
        pause = 1'b1; mode_in = 2'd3; mode_load = 1'b1;
        cyc();
        mode_load = 1'b0;
        check("pp_load_mode", 32'(mode_cur), 32'd3);
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("pp_frozen_led", 32'(led), 32'h1);
        end
        pause = 1'b0;
        exp_q = {32'h2, 32'h4, 32'h8, 32'h4, 32'h2, 32'h1, 32'h2};
        follow("pp4", 32'h1, 1'b0);

        // 5-LED ping-pong: reset release and load on the same edge
        b_rst = 1'b0; b_mode_in = 2'd3; b_mode_load = 1'b1;
        cyc();
        b_mode_load = 1'b0;
        check("pp5_load_led", 32'(b_led), 32'h01);
        check("pp5_load_mode", 32'(b_mode_cur), 32'd3);
        exp_q = {32'h02, 32'h04, 32'h08, 32'h10, 32'h08, 32'h04, 32'h02, 32'h01, 32'h02, 32'h04};
        follow("pp5", 32'h01, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
